// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types and default parameters for the CPU clock controller.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int CNT_WIDTH_DEF       = 26;
  localparam int DIV0_DEF            = 50_000_000;
  localparam int DIV1_DEF            = 5_000_000;
  localparam int DIV2_DEF            = 500_000;
  localparam int DIV3_DEF            = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 250_000;

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the board inputs, the clock controller and the CPU.
interface cpu_clock_ctrl_if;
  logic [1:0]  div_sel;
  logic        run;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_clk;
  logic        cpu_tick;
  logic [1:0]  ctrl_state;
  logic [15:0] tick_count;

  modport master (
    output div_sel, run, step_btn, halt_req,
    input  cpu_clk, cpu_tick, ctrl_state, tick_count
  );

  modport slave (
    input  div_sel, run, step_btn, halt_req,
    output cpu_clk, cpu_tick, ctrl_state, tick_count
  );
endinterface

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Glitch-free CPU clock divider with run/halt/single-step control.
// Optional tick counter enabled by defining CPU_CLOCK_CTRL_TICK_COUNTER_EN.
module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int DIV0            = DIV0_DEF,
  parameter int DIV1            = DIV1_DEF,
  parameter int DIV2            = DIV2_DEF,
  parameter int DIV3            = DIV3_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic            MCLK,
  input logic            reset_clk,
  cpu_clock_ctrl_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] H0_M1 = CNT_WIDTH'(DIV0 / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] H1_M1 = CNT_WIDTH'(DIV1 / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] H2_M1 = CNT_WIDTH'(DIV2 / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] H3_M1 = CNT_WIDTH'(DIV3 / 2 - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, half_m1;
  logic [1:0]           div_reg, div_nxt;
  logic                 clk_q, clk_nxt;
  logic                 tick_q, tick_nxt;
  logic                 run_s1, run_s2;
  logic                 step_level, step_press, start_step;
  logic                 at_top, rise, fall;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_debounce (
    .clk   (MCLK),
    .rst   (reset_clk),
    .btn   (bus.step_btn),
    .level (step_level),
    .press (step_press)
  );

  assign start_step = step_press & step_level;

  always_comb begin
    case (div_reg)
      2'd0:    half_m1 = H0_M1;
      2'd1:    half_m1 = H1_M1;
      2'd2:    half_m1 = H2_M1;
      default: half_m1 = H3_M1;
    endcase
  end

  assign at_top = (cnt == half_m1);
  assign rise   = at_top & ~clk_q;
  assign fall   = at_top & clk_q;

  always_ff @(posedge MCLK or posedge reset_clk) begin
    if (reset_clk) begin
      state   <= IDLE;
      cnt     <= '0;
      div_reg <= 2'd0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      run_s1  <= 1'b0;
      run_s2  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_reg <= div_nxt;
      clk_q   <= clk_nxt;
      tick_q  <= tick_nxt;
      run_s1  <= bus.run;
      run_s2  <= run_s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_reg;
    clk_nxt   = clk_q;
    tick_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        div_nxt = bus.div_sel;
        if (run_s2)          state_nxt = RUN;
        else if (start_step) state_nxt = STEP;
      end
      RUN: begin
        // The would-be rising toggle is the only place the clock may stop.
        if (rise) begin
          cnt_nxt = '0;
          if (bus.halt_req) begin
            state_nxt = HALTED;
          end else if (!run_s2) begin
            state_nxt = IDLE;
          end else begin
            clk_nxt  = 1'b1;
            tick_nxt = 1'b1;
            div_nxt  = bus.div_sel;
          end
        end else if (fall) begin
          cnt_nxt = '0;
          clk_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STEP: begin
        if (rise) begin
          cnt_nxt  = '0;
          clk_nxt  = 1'b1;
          tick_nxt = 1'b1;
          div_nxt  = bus.div_sel;
        end else if (fall) begin
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HALTED: begin
        clk_nxt = 1'b0;
        if (!run_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_clk    = clk_q;
  assign bus.cpu_tick   = tick_q;
  assign bus.ctrl_state = state;

`ifdef CPU_CLOCK_CTRL_TICK_COUNTER_EN
  logic [15:0] tick_cnt;

  always_ff @(posedge MCLK or posedge reset_clk) begin
    if (reset_clk)                          tick_cnt <= '0;
    else if (tick_nxt && tick_cnt != 16'hFFFF) tick_cnt <= tick_cnt + 16'd1;
  end

  assign bus.tick_count = tick_cnt;
`else
  assign bus.tick_count = '0;
`endif
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed self-checking bench for cpu_clock_ctrl (DIV0=4, DIV3=2, DEBOUNCE_CYCLES=4).
module tb_cpu_clock_ctrl;
  logic MCLK = 1'b0;
  logic reset_clk = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ticks_obs = 0;

  cpu_clock_ctrl_if bus();

  cpu_clock_ctrl #(
    .DIV0(4), .DIV3(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .MCLK      (MCLK),
    .reset_clk (reset_clk),
    .bus       (bus)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    if (reset_clk)         ticks_obs = 0;
    else if (bus.cpu_tick) ticks_obs = ticks_obs + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  function automatic logic [15:0] exp_tick_count();
`ifdef CPU_CLOCK_CTRL_TICK_COUNTER_EN
    return ticks_obs[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic wait_state(input logic [1:0] s, input int budget, output int n);
    n = 0;
    while (bus.ctrl_state !== s && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic test_reset();
    bus.div_sel = 2'd0; bus.run = 1'b0; bus.step_btn = 1'b0; bus.halt_req = 1'b0;
    reset_clk = 1'b1;
    cyc(3);
    checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL reset_cpu_clk got %0b exp 0", bus.cpu_clk); end
    checks++; if (bus.cpu_tick !== 1'b0) begin errors++; $display("FAIL reset_cpu_tick got %0b exp 0", bus.cpu_tick); end
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.ctrl_state); end
    checks++; if (bus.tick_count !== 16'd0) begin errors++; $display("FAIL reset_tick_count got %0d exp 0", bus.tick_count); end
    reset_clk = 1'b0;
    cyc(3);
    checks++; if (bus.ctrl_state !== 2'd0 || bus.cpu_clk !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got state %0d clk %0b exp 0 0", bus.ctrl_state, bus.cpu_clk);
    end
  endtask

  task automatic test_run();
    int n;
    bus.run = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (bus.ctrl_state !== 2'd1 && n < 10);
    checks++; if (n !== 3) begin errors++; $display("FAIL run_entry_latency got %0d exp 3", n); end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc(1);
      checks++; if (bus.cpu_clk !== ((k % 4) >= 2)) begin
        errors++; $display("FAIL run_cpu_clk k=%0d got %0b exp %0b", k, bus.cpu_clk, (k % 4) >= 2);
      end
      checks++; if (bus.cpu_tick !== ((k % 4) == 2)) begin
        errors++; $display("FAIL run_cpu_tick k=%0d got %0b exp %0b", k, bus.cpu_tick, (k % 4) == 2);
      end
    end
  endtask

  task automatic test_stop();
    int n = 0;
    while (bus.cpu_tick !== 1'b1 && n < 8) begin cyc(1); n++; end
    checks++; if (bus.cpu_clk !== 1'b1) begin errors++; $display("FAIL stop_pre_high got %0b exp 1", bus.cpu_clk); end
    bus.run = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc(1);
      checks++; if (bus.cpu_clk !== (j == 1)) begin
        errors++; $display("FAIL stop_cpu_clk j=%0d got %0b exp %0b", j, bus.cpu_clk, j == 1);
      end
      checks++; if (bus.cpu_tick !== 1'b0) begin
        errors++; $display("FAIL stop_cpu_tick j=%0d got %0b exp 0", j, bus.cpu_tick);
      end
      checks++; if (bus.ctrl_state !== ((j >= 4) ? 2'd0 : 2'd1)) begin
        errors++; $display("FAIL stop_state j=%0d got %0d exp %0d", j, bus.ctrl_state, (j >= 4) ? 0 : 1);
      end
    end
  endtask

  task automatic test_step();
    int ticks = 0, high = 0, tick_at = -1;
    bit seen_step = 0;
    bus.step_btn = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      cyc(1);
      if (bus.cpu_tick === 1'b1) begin ticks++; tick_at = j; end
      if (bus.cpu_clk === 1'b1) high++;
      if (bus.ctrl_state === 2'd2) seen_step = 1;
      if (j == 8) bus.step_btn = 1'b0;
    end
    checks++; if (ticks !== 1) begin errors++; $display("FAIL step_ticks got %0d exp 1", ticks); end
    checks++; if (tick_at !== 9) begin errors++; $display("FAIL step_tick_pos got %0d exp 9", tick_at); end
    checks++; if (high !== 2) begin errors++; $display("FAIL step_high got %0d exp 2", high); end
    checks++; if (seen_step !== 1'b1) begin errors++; $display("FAIL step_state_seen got %0b exp 1", seen_step); end
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL step_return got %0d exp 0", bus.ctrl_state); end
    cyc(8);
    ticks = 0; seen_step = 0;
    for (int j = 0; j < 16; j++) begin
      if (j < 4) bus.step_btn = (j % 2 == 0);
      else       bus.step_btn = 1'b0;
      cyc(1);
      if (bus.cpu_tick === 1'b1) ticks++;
      if (bus.ctrl_state !== 2'd0) seen_step = 1;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL bounce_ticks got %0d exp 0", ticks); end
    checks++; if (seen_step !== 1'b0) begin errors++; $display("FAIL bounce_left_idle got %0b exp 0", seen_step); end
  endtask

  task automatic test_halt();
    int n, ticks = 0, not_halted = 0;
    bus.run = 1'b1;
    wait_state(2'd1, 10, n);
    bus.halt_req = 1'b1;
    wait_state(2'd3, 12, n);
    checks++; if (bus.ctrl_state !== 2'd3) begin errors++; $display("FAIL halt_entry got %0d exp 3", bus.ctrl_state); end
    checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL halt_cpu_clk got %0b exp 0", bus.cpu_clk); end
    bus.halt_req = 1'b0;
    bus.step_btn = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      cyc(1);
      if (bus.cpu_tick === 1'b1) ticks++;
      if (bus.ctrl_state !== 2'd3) not_halted++;
      if (j == 8) bus.step_btn = 1'b0;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL halt_step_ticks got %0d exp 0", ticks); end
    checks++; if (not_halted !== 0) begin errors++; $display("FAIL halt_held got %0d exp 0", not_halted); end
    bus.run = 1'b0;
    cyc(2);
    checks++; if (bus.ctrl_state !== 2'd3) begin errors++; $display("FAIL halt_sync_delay got %0d exp 3", bus.ctrl_state); end
    cyc(1);
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL halt_exit got %0d exp 0", bus.ctrl_state); end
    ticks = 0;
    for (int j = 0; j < 8; j++) begin cyc(1); if (bus.cpu_tick === 1'b1) ticks++; end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL halt_stale_press got %0d exp 0", ticks); end
  endtask

  task automatic test_div_change();
    int n, ticks = 0;
    int pos[4] = '{-1, -1, -1, -1};
    int exp_pos[4] = '{4, 6, 8, 10};
    logic clk4, clk5;
    bus.div_sel = 2'd0;
    bus.run = 1'b1;
    wait_state(2'd1, 10, n);
    n = 0;
    while (bus.cpu_tick !== 1'b1 && n < 8) begin cyc(1); n++; end
    checks++; if (bus.cpu_tick !== 1'b1) begin errors++; $display("FAIL div_first_tick got %0b exp 1", bus.cpu_tick); end
    clk4 = 1'bx; clk5 = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (k == 1) bus.div_sel = 2'd3;
      if (k == 4) clk4 = bus.cpu_clk;
      if (k == 5) clk5 = bus.cpu_clk;
      if (bus.cpu_tick === 1'b1) begin
        if (ticks < 4) pos[ticks] = k;
        ticks++;
      end
    end
    checks++; if (ticks !== 4) begin errors++; $display("FAIL div_tick_count got %0d exp 4", ticks); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pos[i] !== exp_pos[i]) begin
        errors++; $display("FAIL div_tick_pos i=%0d got %0d exp %0d", i, pos[i], exp_pos[i]);
      end
    end
    checks++; if (clk4 !== 1'b1 || clk5 !== 1'b0) begin
      errors++; $display("FAIL div_fast_duty got %0b%0b exp 10", clk4, clk5);
    end
    bus.run = 1'b0;
    wait_state(2'd0, 12, n);
    cyc(2);
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL div_stop got %0d exp 0", bus.ctrl_state); end
    checks++; if (bus.tick_count !== exp_tick_count()) begin
      errors++; $display("FAIL tick_count got %0d exp %0d", bus.tick_count, exp_tick_count());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.div_sel = 2'd0;
    bus.run = 1'b1;
    wait_state(2'd1, 10, n);
    n = 0;
    while (bus.cpu_tick !== 1'b1 && n < 8) begin cyc(1); n++; end
    checks++; if (bus.cpu_clk !== 1'b1) begin errors++; $display("FAIL rstmid_pre_high got %0b exp 1", bus.cpu_clk); end
    #1 reset_clk = 1'b1;
    #1;
    checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_clk got %0b exp 0", bus.cpu_clk); end
    checks++; if (bus.cpu_tick !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_tick got %0b exp 0", bus.cpu_tick); end
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", bus.ctrl_state); end
    checks++; if (bus.tick_count !== 16'd0) begin errors++; $display("FAIL rstmid_tick_count got %0d exp 0", bus.tick_count); end
    bus.run = 1'b0;
    cyc(2);
    reset_clk = 1'b0;
    cyc(4);
    checks++; if (bus.ctrl_state !== 2'd0 || bus.cpu_clk !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got state %0d clk %0b exp 0 0", bus.ctrl_state, bus.cpu_clk);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop();
    test_step();
    test_halt();
    test_div_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
